mux4_1_sel: RTL and testbench

//   16-bit (parameterised) 4-to-1 word multiplexer for the datapath.

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux2_1.sv | 20 ++
 rtl/mux4_1_sel.sv | 55 +++++
 tb/tb_mux4_1_sel.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select-code definitions for the datapath word multiplexers.
package mux_pkg;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;
    localparam logic [1:0] SEL_D3 = 2'b11;

    function automatic logic [1:0] sel_code(input logic s1, input logic s0);
        return {s1, s0};
    endfunction

endpackage

// File: rtl/mux2_1.sv
// 2-to-1 word multiplexer: Y = S ? B : A, with an unknown select giving an all-X word.
module mux2_1 #(
    parameter int WIDTH = 16
) (
    input  logic             S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    // A case statement rather than ?: so an X/Z select yields all-X instead of merged bits.
    always_comb begin
        case (S)
            1'b0:    Y = A;
            1'b1:    Y = B;
            default: Y = 'x;
        endcase
    end

endmodule

// File: rtl/mux4_1_sel.sv
// 4-to-1 word multiplexer built as a tree of mux2_1 cells.
// Define MUX4_1_OUT_REG_EN to register O (synchronous active-high RST clears it).
module mux4_1_sel
    import mux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic             S0,
    input  logic             S1,
    output logic [WIDTH-1:0] O
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] lo_y;
    logic [WIDTH-1:0] hi_y;
    logic [WIDTH-1:0] mux_y;

    assign sel = sel_code(S1, S0);

    mux2_1 #(.WIDTH(WIDTH)) u_mux_lo (.S(sel[0]), .A(D0),   .B(D1),   .Y(lo_y));
    mux2_1 #(.WIDTH(WIDTH)) u_mux_hi (.S(sel[0]), .A(D2),   .B(D3),   .Y(hi_y));
    mux2_1 #(.WIDTH(WIDTH)) u_mux_o  (.S(sel[1]), .A(lo_y), .B(hi_y), .Y(mux_y));

`ifdef MUX4_1_OUT_REG_EN
    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;

    always_comb begin
        o_d = mux_y;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    assign O = o_q;
`else
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST;

    assign O = mux_y;
`endif

endmodule

// File: tb/tb_mux4_1_sel.sv
// Scoreboard bench for mux4_1_sel: randomised and directed vectors against an array-indexing model.
module tb_mux4_1_sel;
    import mux_pkg::*;

    localparam int WIDTH = 16;
`ifdef MUX4_1_OUT_REG_EN
    localparam int LATENCY = 1;
`else
    localparam int LATENCY = 0;
`endif

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               due;
        string            name;
    } item_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic             s0 = 1'b0, s1 = 1'b0;
    logic [WIDTH-1:0] o;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    finishing = 1'b0;
    item_t sb_q[$];

    mux4_1_sel #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .RST(rst),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3),
        .S0(s0), .S1(s1), .O(o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the output is simply the data word indexed by the select code.
    function automatic logic [WIDTH-1:0] modelOut(input logic [WIDTH-1:0] a, b, c, d,
                                                  input logic hs1, hs0, input logic hrst);
        logic [WIDTH-1:0] words [4];
        logic [1:0]       idx;
        words[0] = a; words[1] = b; words[2] = c; words[3] = d;
        idx = {hs1, hs0};
        if (LATENCY == 1 && hrst) return '0;
        if ($isunknown(idx)) return 'x;
        return words[idx];
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] a, b, c, d,
                                 input logic hs1, hs0, input logic hrst, input string name);
        item_t it;
        @(posedge clk);
        #1;
        d0 = a; d1 = b; d2 = c; d3 = d;
        s1 = hs1; s0 = hs0; rst = hrst;
        it.exp  = modelOut(a, b, c, d, hs1, hs0, hrst);
        it.due  = cyc + LATENCY;
        it.name = name;
        sb_q.push_back(it);
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: O=%h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops whatever is due this cycle and compares away from the active edge.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                it = sb_q.pop_front();
                checkOutput(it.name, o, it.exp);
            end
            if (finishing) begin
                checks++;
                if (sb_q.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL drain: %0d pending expected 0", sb_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        logic [1:0] code;
`ifdef MUX4_1_OUT_REG_EN
        applyStimulus(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1, 1'b1, 1'b1, "reset1");
        applyStimulus(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1, 1'b1, 1'b1, "reset2");
        applyStimulus(16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0, "release");
        applyStimulus(16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0, "hold_beef");
        applyStimulus(16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b1, "mid_reset");
        applyStimulus(16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0, "reload");
        applyStimulus(16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0, "reload_hold");
`endif
        for (int i = 0; i < 4; i++) begin
            code = SEL_D0 + 2'(i);
            applyStimulus(16'h1111, 16'h2222, 16'h4444, 16'h8888, code[1], code[0], 1'b0, "sweep");
        end
        applyStimulus(16'h1111, 16'h2222, 16'h4444, 16'h0000, SEL_D3[1], SEL_D3[0], 1'b0, "d3_track0");
        applyStimulus(16'h1111, 16'h2222, 16'h4444, 16'hFFFF, SEL_D3[1], SEL_D3[0], 1'b0, "d3_trackF");
        applyStimulus(16'h1111, 16'h2222, 16'h4444, 16'hA5A5, SEL_D3[1], SEL_D3[0], 1'b0, "d3_trackA5");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(WIDTH'($urandom), 16'h2222, WIDTH'($urandom), WIDTH'($urandom),
                          SEL_D1[1], SEL_D1[0], 1'b0, "d1_stable");
        end
        for (int i = 0; i < 1000; i++) begin
            code = 2'($urandom_range(0, 3));
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                          code[1], code[0], 1'b0, "random");
        end
`ifndef MUX4_1_OUT_REG_EN
        applyStimulus(16'hC3C3, 16'h3C3C, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b1, "rst_ignored");
        applyStimulus(16'h1111, 16'h1111, 16'h4444, 16'h8888, 1'b0, 1'bx, 1'b0, "sel_x_lsb");
        applyStimulus(16'h1111, 16'h2222, 16'h1111, 16'h8888, 1'bx, 1'b0, 1'b0, "sel_x_msb");
`endif
        repeat (2) @(posedge clk);
        finishing = 1'b1;
    end

    // Hard stop in case the monitor never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish by 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
